// File: rtl/mips_pkg.sv
// Types and field constants shared by the fetch stage, its target calculator and
// the decode-facing interface.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_HOLD,
      ST_HOLD_FETCH,
      ST_HOLD_FULL,
      ST_DROP
   } fetch_state_e;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int FUNC_MSB = 5;
   localparam int FUNC_LSB = 0;

   localparam logic [1:0] JUMP_J   = 2'b01;
   localparam logic [1:0] JUMP_JAL = 2'b10;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory, decode and redirect signals around the fetch stage.
// master = fetch unit, slave = memory/decode side.
interface fetch_unit_if;
   import mips_pkg::*;

   // imem: a transfer completes on any cycle with imem_req && imem_valid; imem_addr is
   // stable while imem_req is high. decode: an instruction is accepted on if_valid &&
   // if_ready; if_instr/if_pc stay stable while if_valid is high and not accepted.
   logic         imem_req;
   logic [31:0]  imem_addr;
   logic         imem_valid;
   logic [31:0]  imem_rdata;

   logic         if_valid;
   logic         if_ready;
   logic [31:0]  if_instr;
   logic [31:0]  if_pc;
   logic [5:0]   if_opcode;
   logic [5:0]   if_func;

   logic [1:0]   redir_jump;
   logic         redir_jr;
   logic         redir_branch;
   logic [31:0]  redir_rs;

   fetch_state_e state_dbg;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, if_func, state_dbg,
      input  imem_valid, imem_rdata, if_ready, redir_jump, redir_jr, redir_branch, redir_rs
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode, if_func, state_dbg,
      output imem_valid, imem_rdata, if_ready, redir_jump, redir_jr, redir_branch, redir_rs
   );

endinterface

// File: rtl/fetch_target_calc.sv
// Redirect priority mux: jr > j/jal > taken branch. Without a redirect the target is
// the sequential address, so the caller can use target unconditionally.
module fetch_target_calc
   import mips_pkg::*;
(
   input  logic [31:0] if_pc,
   input  logic [25:0] instr_low,
   input  logic [1:0]  redir_jump,
   input  logic        redir_jr,
   input  logic        redir_branch,
   input  logic [31:0] redir_rs,
   output logic        redirect,
   output logic [31:0] target
);

   logic [31:0] pc4;
   logic [31:0] jump_tgt;
   logic [31:0] branch_tgt;
   logic        is_jump;

   assign pc4        = if_pc + 32'd4;
   assign is_jump    = (redir_jump == JUMP_J) || (redir_jump == JUMP_JAL);
   assign jump_tgt   = {pc4[31:28], instr_low, 2'b00};
   assign branch_tgt = pc4 + {{14{instr_low[15]}}, instr_low[15:0], 2'b00};

   always_comb begin
      redirect = 1'b1;
      target   = pc4;
      if (redir_jr) begin
         target = redir_rs;
      end else if (is_jump) begin
         target = jump_tgt;
      end else if (redir_branch) begin
         target = branch_tgt;
      end else begin
         redirect = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, one-deep prefetch buffer,
// and PC redirect on jr/jump/taken-branch accepted by decode.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          PREFETCH_EN = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   fetch_state_e state_q, state_d;
   logic         imem_req_q, imem_req_d;
   logic [31:0]  imem_addr_q, imem_addr_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [31:0]  redir_pc_q, redir_pc_d;

   logic         redirect;
   logic [31:0]  target;
   logic         done;
   logic         accept;
   logic         take;

   fetch_target_calc u_target (
      .if_pc        (if_pc_q),
      .instr_low    (if_instr_q[25:0]),
      .redir_jump   (bus.redir_jump),
      .redir_jr     (bus.redir_jr),
      .redir_branch (bus.redir_branch),
      .redir_rs     (bus.redir_rs),
      .redirect     (redirect),
      .target       (target)
   );

   assign done   = imem_req_q && bus.imem_valid;
   assign accept = if_valid_q && bus.if_ready;
   assign take   = accept && redirect;

   always_comb begin
      state_d     = state_q;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      buf_instr_d = buf_instr_q;
      redir_pc_d  = redir_pc_q;

      unique case (state_q)
         ST_IDLE: begin
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_FETCH: begin
            if (done) begin
               if_valid_d = 1'b1;
               if_instr_d = bus.imem_rdata;
               if_pc_d    = imem_addr_q;
               if (PREFETCH_EN) begin
                  imem_addr_d = imem_addr_q + 32'd4;
                  state_d     = ST_HOLD_FETCH;
               end else begin
                  imem_req_d = 1'b0;
                  state_d    = ST_HOLD;
               end
            end
         end

         // target equals if_pc+4 when no redirect is requested
         ST_HOLD: begin
            if (accept) begin
               if_valid_d  = 1'b0;
               imem_req_d  = 1'b1;
               imem_addr_d = target;
               state_d     = ST_FETCH;
            end
         end

         ST_HOLD_FETCH: begin
            if (take) begin
               if_valid_d = 1'b0;
               if (done) begin
                  imem_addr_d = target;
                  state_d     = ST_FETCH;
               end else begin
                  redir_pc_d = target;
                  state_d    = ST_DROP;
               end
            end else if (done && accept) begin
               if_instr_d  = bus.imem_rdata;
               if_pc_d     = imem_addr_q;
               imem_addr_d = imem_addr_q + 32'd4;
            end else if (done) begin
               buf_instr_d = bus.imem_rdata;
               imem_req_d  = 1'b0;
               state_d     = ST_HOLD_FULL;
            end else if (accept) begin
               if_valid_d = 1'b0;
               state_d    = ST_FETCH;
            end
         end

         // imem_addr_q still holds the buffered word's address here
         ST_HOLD_FULL: begin
            if (accept) begin
               imem_req_d = 1'b1;
               if (take) begin
                  if_valid_d  = 1'b0;
                  imem_addr_d = target;
                  state_d     = ST_FETCH;
               end else begin
                  if_instr_d  = buf_instr_q;
                  if_pc_d     = imem_addr_q;
                  imem_addr_d = imem_addr_q + 32'd4;
                  state_d     = ST_HOLD_FETCH;
               end
            end
         end

         ST_DROP: begin
            if (done) begin
               imem_addr_d = redir_pc_q;
               state_d     = ST_FETCH;
            end
         end

         default: begin
            imem_req_d = 1'b0;
            if_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
         if_valid_q  <= 1'b0;
         if_instr_q  <= 32'h0;
         if_pc_q     <= 32'h0;
         buf_instr_q <= 32'h0;
         redir_pc_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         buf_instr_q <= buf_instr_d;
         redir_pc_q  <= redir_pc_d;
      end
   end

   assign bus.imem_req  = imem_req_q;
   assign bus.imem_addr = imem_addr_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_opcode = if_instr_q[OPC_MSB:OPC_LSB];
   assign bus.if_func   = if_instr_q[FUNC_MSB:FUNC_LSB];
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a random phase, every accepted
// instruction checked against a program-order PC model over a synthetic memory image.
module tb_fetch_unit;
   import mips_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC), .PREFETCH_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   logic [31:0] model_pc = RESET_PC;

   int          lat_fixed = 1;   // < 0 selects a random latency per request
   int          stray_mode = 0;  // 0 none, 1 random, 2 every idle cycle
   int          mem_mode = 0;    // 0 constant word, 1 address hash
   logic [31:0] req_log[$];
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h1000_FFFC;
      if (a == 32'h8000_0000) return 32'h0800_0040;
      if (mem_mode == 0) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Program-order successor of an accepted instruction
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                              input logic [1:0] jmp, input logic jr,
                                              input logic br, input logic [31:0] rs);
      logic [31:0] pc4;
      int          off;
      pc4 = pc + 32'd4;
      if (jr) return rs;
      if (jmp == 2'b01 || jmp == 2'b10)
         return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (br) begin
         off = int'($signed(w[15:0])) * 4;
         return pc4 + 32'(off);
      end
      return pc4;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction memory: logs each new request, answers after lat cycles
   initial begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         bus.imem_valid = 1'b0;
         if (bus.imem_req) begin
            if (!mem_busy) begin
               mem_busy = 1'b1;
               mem_cnt  = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
               req_log.push_back(bus.imem_addr);
            end
            if (mem_cnt == 0) begin
               bus.imem_valid = 1'b1;
               bus.imem_rdata = mem_word(bus.imem_addr);
               mem_busy       = 1'b0;
            end else begin
               mem_cnt--;
            end
         end else begin
            mem_busy = 1'b0;
            if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) begin
               bus.imem_valid = 1'b1;
               bus.imem_rdata = 32'hDEAD_BEEF;
            end
         end
      end
   end

   task automatic step(input logic rdy, input logic [1:0] jmp, input logic jr,
                       input logic br, input logic [31:0] rs);
      logic [31:0] w;
      @(negedge clk);
      bus.if_ready     = rdy;
      bus.redir_jump   = jmp;
      bus.redir_jr     = jr;
      bus.redir_branch = br;
      bus.redir_rs     = rs;
      if (bus.if_valid && rdy) begin
         w = mem_word(model_pc);
         check32("accept_pc", bus.if_pc, model_pc);
         check32("accept_instr", bus.if_instr, w);
         check32("accept_opc_func", {20'd0, bus.if_opcode, bus.if_func},
                 {20'd0, w[31:26], w[5:0]});
         model_pc = model_next(model_pc, w, jmp, jr, br, rs);
         n_acc++;
      end
   endtask

   task automatic go(input logic rdy);
      step(rdy, 2'b00, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic wait_valid(input string tag);
      int cyc;
      cyc = 0;
      do begin
         go(1'b0);
         cyc++;
      end while (!bus.if_valid && cyc < 40);
      check32(tag, 32'(bus.if_valid), 32'd1);
   endtask

   task automatic run_accepts(input int n, input string tag);
      int start;
      int cyc;
      start = n_acc;
      cyc = 0;
      while (n_acc - start < n && cyc < 200) begin
         go(1'b1);
         cyc++;
      end
      check32(tag, 32'(n_acc - start), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.if_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_pc = RESET_PC;
   endtask

   task automatic check_reset_vals(input string tag);
      check32({tag, "_req"}, 32'(bus.imem_req), 32'd0);
      check32({tag, "_addr"}, bus.imem_addr, RESET_PC);
      check32({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
      check32({tag, "_instr"}, bus.if_instr, 32'h0);
      check32({tag, "_pc"}, bus.if_pc, 32'h0);
      check32({tag, "_state"}, 32'(bus.state_dbg), 32'(ST_IDLE));
   endtask

   initial begin
      int          lb;
      int          cyc;
      int          acc0;
      int          r;
      logic [31:0] expv;
      logic        rdy;
      logic [1:0]  jmp;
      logic        jr;
      logic        br;
      logic [31:0] rs;

      bus.if_ready     = 1'b0;
      bus.redir_jump   = 2'b00;
      bus.redir_jr     = 1'b0;
      bus.redir_branch = 1'b0;
      bus.redir_rs     = 32'h0;

      // Reset values, first fetch, first presented instruction
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      model_pc = RESET_PC;
      lb = req_log.size();
      go(1'b0);
      check32("first_req", 32'(bus.imem_req), 32'd1);
      check32("first_addr", bus.imem_addr, 32'h0);
      wait_valid("first_valid");
      check32("first_if_pc", bus.if_pc, 32'h0);
      check32("first_opcode", 32'(bus.if_opcode), 32'(6'b001000));
      check32("first_func", 32'(bus.if_func), 32'(6'b000101));
      check32("prefetch_addr", bus.imem_addr, 32'h4);

      // Decode stalls 5 cycles: one prefetch, word parked in the buffer
      repeat (5) go(1'b0);
      check32("stall_req_count", 32'(req_log.size() - lb), 32'd2);
      check32("stall_state", 32'(bus.state_dbg), 32'(ST_HOLD_FULL));
      check32("stall_req_low", 32'(bus.imem_req), 32'd0);
      run_accepts(3, "stall_release");
      check32("stall_log_len", 32'(req_log.size() - lb >= 3), 32'd1);
      if (req_log.size() - lb >= 3) begin
         check32("stall_log1", req_log[lb + 1], 32'h4);
         check32("stall_log2", req_log[lb + 2], 32'h8);
      end

      // Taken branch at 0x10 while the 0x14 prefetch is still in flight
      do_reset();
      lat_fixed = 3;
      cyc = 0;
      while (model_pc != 32'h10 && cyc < 200) begin
         go(1'b1);
         cyc++;
      end
      cyc = 0;
      while (!(bus.if_valid && bus.imem_req && bus.imem_addr == 32'h14) && cyc < 40) begin
         go(1'b0);
         cyc++;
      end
      check32("br_if_pc", bus.if_pc, 32'h10);
      check32("br_state", 32'(bus.state_dbg), 32'(ST_HOLD_FETCH));
      check32("br_inflight", 32'(bus.imem_valid), 32'd0);
      lb = req_log.size();
      step(1'b1, 2'b00, 1'b0, 1'b1, 32'h0);
      go(1'b0);
      check32("br_drop_state", 32'(bus.state_dbg), 32'(ST_DROP));
      check32("br_drop_valid", 32'(bus.if_valid), 32'd0);
      run_accepts(1, "br_target_accept");
      check32("br_target_req", (req_log.size() > lb) ? req_log[lb] : 32'hFFFF_FFFF, 32'h4);

      // j at 0x8000_0000, then jr and j together
      lat_fixed = 1;
      wait_valid("jr_setup_valid");
      step(1'b1, 2'b00, 1'b1, 1'b0, 32'h8000_0000);
      wait_valid("j_valid");
      check32("j_if_pc", bus.if_pc, 32'h8000_0000);
      step(1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
      wait_valid("j_target_valid");
      check32("j_target_pc", bus.if_pc, 32'h8000_0100);
      step(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0200);
      wait_valid("jr_prio_valid");
      check32("jr_prio_pc", bus.if_pc, 32'h0000_0200);

      // Redirect without if_ready is ignored
      expv = model_pc + 32'd4;
      repeat (3) step(1'b0, 2'b01, 1'b1, 1'b1, 32'h0000_1234);
      step(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
      wait_valid("ignored_valid");
      check32("ignored_seq_pc", bus.if_pc, expv);

      // Reset while the 0x20 request is outstanding, with stray strobes afterwards
      do_reset();
      lat_fixed = 3;
      cyc = 0;
      while (!(bus.imem_req && bus.imem_addr == 32'h20) && cyc < 200) begin
         go(1'b1);
         cyc++;
      end
      check32("mid_rst_at_0x20", bus.imem_addr, 32'h20);
      rst_n = 1'b0;
      stray_mode = 2;
      #1;
      check_reset_vals("mid_rst");
      repeat (3) @(negedge clk);
      check_reset_vals("mid_rst_stray");
      rst_n = 1'b1;
      model_pc = RESET_PC;
      lb = req_log.size();
      run_accepts(2, "mid_rst_restart");
      stray_mode = 0;
      check32("mid_rst_first_req", (req_log.size() > lb) ? req_log[lb] : 32'hFFFF_FFFF, RESET_PC);

      // Random traffic: latency, stalls, strays and redirects
      do_reset();
      mem_mode = 1;
      lat_fixed = -1;
      stray_mode = 1;
      acc0 = n_acc;
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(0, 3) != 0);
         jmp = 2'b00;
         jr = 1'b0;
         br = 1'b0;
         rs = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         r = int'($urandom_range(0, 9));
         if (r == 0) jr = 1'b1;
         else if (r == 1) jmp = 2'($urandom_range(1, 3));
         else if (r == 2) br = 1'b1;
         else if (r == 3) begin
            jmp = 2'($urandom_range(0, 3));
            jr = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
         end
         step(rdy, jmp, jr, br, rs);
      end
      stray_mode = 0;
      check32("random_progress", 32'(n_acc - acc0 >= 300), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
